vga_sync: RTL

// - 640x480@60 VGA timing generator and pixel output stage for the air hockey design.
// - Upstream of the game logic: drives the xpos/ypos scan coordinates that the game logic consumes.
// - Downstream of the game logic: takes its 8-bit RGB, blanks it outside the visible area and

---
 rtl/vga_sync_if.sv | 31 +++
 rtl/vga_sync.sv | 109 ++++++++++
 2 files changed

// File: rtl/vga_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_if
// Purpose  : Scan-coordinate, pixel-data and pin bundle for the VGA timing stage.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_sync_if;
  logic [2:0] red_in;
  logic [2:0] green_in;
  logic [1:0] blue_in;
  logic [9:0] xpos;
  logic [9:0] ypos;
  logic       pix_en;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;

  // master: the timing generator; slave: game logic plus pin consumer
  modport master (
    input  red_in, green_in, blue_in,
    output xpos, ypos, pix_en, frame_start, hsync, vsync, red, green, blue
  );
  modport slave (
    output red_in, green_in, blue_in,
    input  xpos, ypos, pix_en, frame_start, hsync, vsync, red, green, blue
  );
endinterface
`default_nettype wire

// File: rtl/vga_sync.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync
// Purpose  : 640x480@60 VGA timing generator with blanked, registered RGB output.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  vga_sync_if.master       vga
);

  localparam int          c_h_total  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int          c_v_total  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int          c_div_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [9:0]  c_h_last   = 10'(c_h_total - 1);
  localparam logic [9:0]  c_v_last   = 10'(c_v_total - 1);
  localparam logic [9:0]  c_h_vis    = 10'(H_VISIBLE);
  localparam logic [9:0]  c_v_vis    = 10'(V_VISIBLE);
  localparam logic [9:0]  c_hs_first = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]  c_hs_last  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  c_vs_first = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  c_vs_last  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [c_div_w-1:0] r_div_cnt;
  logic [9:0]         r_xpos;
  logic [9:0]         r_ypos;
  logic               r_hsync;
  logic               r_vsync;
  logic [2:0]         r_red;
  logic [2:0]         r_green;
  logic [1:0]         r_blue;

  logic w_pix_en;
  logic w_x_last;
  logic w_y_last;
  logic w_hs_active;
  logic w_vs_active;
  logic w_visible;

  // With CLK_DIV=1 the divider is stuck at 0, so pix_en stays high even in reset.
  assign w_pix_en    = (r_div_cnt == c_div_last);
  assign w_x_last    = (r_xpos == c_h_last);
  assign w_y_last    = (r_ypos == c_v_last);
  assign w_hs_active = (r_xpos >= c_hs_first) && (r_xpos <= c_hs_last);
  assign w_vs_active = (r_ypos >= c_vs_first) && (r_ypos <= c_vs_last);
  assign w_visible   = (r_xpos < c_h_vis) && (r_ypos < c_v_vis);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_xpos    <= '0;
      r_ypos    <= '0;
    end else begin
      if (w_pix_en) begin
        r_div_cnt <= '0;
        if (w_x_last) begin
          r_xpos <= '0;
          r_ypos <= w_y_last ? 10'd0 : r_ypos + 10'd1;
        end else begin
          r_xpos <= r_xpos + 10'd1;
        end
      end else begin
        r_div_cnt <= r_div_cnt + c_div_w'(1);
      end
    end
  end

  // Pin stage samples the current coordinates, so it trails them by one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_hsync <= w_hs_active ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_vs_active ? SYNC_POL : ~SYNC_POL;
      r_red   <= w_visible ? vga.red_in   : 3'd0;
      r_green <= w_visible ? vga.green_in : 3'd0;
      r_blue  <= w_visible ? vga.blue_in  : 2'd0;
    end
  end

  assign vga.xpos        = r_xpos;
  assign vga.ypos        = r_ypos;
  assign vga.pix_en      = w_pix_en;
  assign vga.frame_start = w_pix_en && w_x_last && w_y_last;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.red         = r_red;
  assign vga.green       = r_green;
  assign vga.blue        = r_blue;

endmodule
`default_nettype wire
